// File: rtl/freq_meter.sv
// Rising-edge frequency meter: counts qualified edges of an asynchronous input
// over a GATE_CYCLES-long window and publishes the count with a valid strobe.
module freq_meter #(
  parameter int unsigned GATE_CYCLES = 100000000,
  parameter int unsigned CNT_W       = 27
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] freq,
  output logic             freq_valid,
  output logic             overflow,
  output logic             busy
);

  localparam int unsigned GW = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ARM, MEASURE, REPORT} state_e;

  state_e           state_q;
  logic             s1_q, s2_q, s3_q;
  logic [1:0]       prime_q;
  logic [GW-1:0]    gate_q;
  logic [CNT_W-1:0] edge_q, edge_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] freq_q;
  logic             overflow_q, valid_q, busy_q;
  logic             rise;

  // Edges are only trusted once the synchronizer and history flop hold real samples.
  assign rise = s2_q & ~s3_q & (prime_q == 2'd3);

  always_comb begin
    edge_d = edge_q;
    ovf_d  = ovf_q;
    if (rise) begin
      if (&edge_q) ovf_d  = 1'b1;
      else         edge_d = edge_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      s3_q       <= 1'b0;
      prime_q    <= '0;
      gate_q     <= '0;
      edge_q     <= '0;
      ovf_q      <= 1'b0;
      freq_q     <= '0;
      overflow_q <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      s1_q    <= sig_in;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      if (prime_q != 2'd3) prime_q <= prime_q + 2'd1;
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          gate_q <= '0;
          edge_q <= '0;
          ovf_q  <= 1'b0;
          if (en) begin
            state_q <= ARM;
            busy_q  <= 1'b1;
          end
        end
        ARM: begin
          gate_q  <= '0;
          edge_q  <= '0;
          ovf_q   <= 1'b0;
          state_q <= MEASURE;
        end
        MEASURE: begin
          if (!en) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (gate_q == GATE_LAST) begin
            // Publish the next-state count so an edge on the last cycle is included.
            freq_q     <= edge_d;
            overflow_q <= ovf_d;
            valid_q    <= 1'b1;
            state_q    <= REPORT;
          end else begin
            gate_q <= gate_q + 1'b1;
            edge_q <= edge_d;
            ovf_q  <= ovf_d;
          end
        end
        REPORT: begin
          gate_q <= '0;
          edge_q <= '0;
          ovf_q  <= 1'b0;
          if (en) begin
            state_q <= MEASURE;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign freq       = freq_q;
  assign freq_valid = valid_q;
  assign overflow   = overflow_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_freq_meter.sv
// Scoreboard bench for freq_meter: a 27-bit and a 4-bit instance share stimulus;
// expected reports are queued when a window is started and popped on freq_valid.
module tb_freq_meter;

  localparam int unsigned GATE = 100;

  logic        clk = 1'b0;
  logic        rst, en, sig_in;
  logic [26:0] freq;
  logic        freq_valid, overflow, busy;
  logic [3:0]  freq_s;
  logic        freq_valid_s, overflow_s, busy_s;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int per   = 0;
  int ph    = 0;

  typedef struct {
    int     cyc;
    longint f;
    bit     ovf;
  } exp_t;

  exp_t q[$];
  exp_t qs[$];
  longint last_f, last_fs;
  bit     last_o, last_os;

  freq_meter #(.GATE_CYCLES(GATE), .CNT_W(27)) dut (
    .clk(clk), .rst(rst), .en(en), .sig_in(sig_in),
    .freq(freq), .freq_valid(freq_valid), .overflow(overflow), .busy(busy)
  );

  freq_meter #(.GATE_CYCLES(GATE), .CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .en(en), .sig_in(sig_in),
    .freq(freq_s), .freq_valid(freq_valid_s), .overflow(overflow_s), .busy(busy_s)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", tag, obs, expv, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Periodic stimulus: per==0 holds low, otherwise high for the first half of each period.
  initial begin
    sig_in = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      sig_in = (per == 0) ? 1'b0 : (((cyc + ph) % per) < (per / 2));
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (freq_valid) begin
      if (q.size() == 0) chk("spurious_valid", 1, 0);
      else begin
        e = q.pop_front();
        chk("valid_cyc", cyc, e.cyc);
        chk("freq", freq, e.f);
        chk("overflow", overflow, e.ovf);
      end
    end
    if (freq_valid_s) begin
      if (qs.size() == 0) chk("spurious_valid_s", 1, 0);
      else begin
        e = qs.pop_front();
        chk("valid_cyc_s", cyc, e.cyc);
        chk("freq_s", freq_s, e.f);
        chk("overflow_s", overflow_s, e.ovf);
      end
    end
  end

  task automatic push_exp(input int at, input int edges);
    exp_t e;
    e.cyc = at; e.f = edges; e.ovf = 1'b0;
    q.push_back(e);
    e.f = (edges > 15) ? 15 : edges; e.ovf = (edges > 15);
    qs.push_back(e);
    last_f = edges; last_o = 1'b0;
    last_fs = e.f; last_os = e.ovf;
  endtask

  task automatic wait_valid(input int n);
    bit got = 1'b0;
    for (int i = 0; i < n && !got; i++) begin
      step();
      got = freq_valid;
    end
    if (!got) chk("timeout_valid", 0, 1);
  endtask

  task automatic run_window(input int edges);
    push_exp(cyc + GATE + 2, edges);
    en = 1'b1;
    wait_valid(2 * GATE);
    en = 1'b0;
    repeat (4) step();
  endtask

  initial begin
    int c0;
    rst = 1'b0;
    en  = 1'b0;
    last_f = 0; last_fs = 0; last_o = 0; last_os = 0;

    // Reset held with activity on the inputs.
    en = 1'b1; per = 2;
    repeat (5) begin
      step();
      chk("rst_freq", freq, 0);
      chk("rst_valid", freq_valid, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_busy", busy, 0);
    end
    en = 1'b0; per = 0;
    step();
    rst = 1'b1;
    repeat (5) step();

    // Nominal: period 10 at every phase offset gives 10 edges.
    per = 10;
    for (int p = 0; p < 10; p++) begin
      ph = p;
      repeat (3) step();
      run_window(10);
    end

    // Maximum rate; the 4-bit instance saturates. Then a silent window clears overflow.
    per = 2; ph = 0;
    repeat (3) step();
    run_window(50);
    per = 0;
    repeat (3) step();
    run_window(0);

    // Continuous mode with period 4: strobes 101 cycles apart.
    per = 4;
    repeat (3) step();
    c0 = cyc;
    push_exp(c0 + GATE + 2, 25);
    push_exp(c0 + 2 * GATE + 3, 25);
    push_exp(c0 + 3 * GATE + 4, 25);
    en = 1'b1;
    repeat (3) wait_valid(2 * GATE);
    en = 1'b0;
    repeat (4) step();

    // Abort at MEASURE cycle 40: no report, outputs hold, busy drops one cycle later.
    per = 2;
    en = 1'b1;
    repeat (42) step();
    chk("abort_busy_before", busy, 1);
    en = 1'b0;
    step();
    chk("abort_busy_after", busy, 0);
    chk("abort_freq_hold", freq, last_f);
    chk("abort_ovf_hold", overflow, last_o);
    chk("abort_freq_s_hold", freq_s, last_fs);
    chk("abort_ovf_s_hold", overflow_s, last_os);
    repeat (2 * GATE) step();

    // Reset mid-window discards the window and clears outputs.
    en = 1'b1;
    repeat (50) step();
    rst = 1'b0;
    en  = 1'b0;
    step();
    chk("midrst_freq", freq, 0);
    chk("midrst_valid", freq_valid, 0);
    chk("midrst_ovf", overflow, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ovf_s", overflow_s, 0);
    step();
    rst = 1'b1;
    repeat (2 * GATE) step();
    chk("final_freq", freq, 0);

    chk("pending_reports", q.size(), 0);
    chk("pending_reports_s", qs.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
